// File: rtl/video_fetch_fifo.sv
// Assembles WORDS 16-bit DRAM words into one fetch line and queues complete lines in a DEPTH-entry buffer.
// Optional build macro VIDEO_FETCH_BSWAP_EN enables byte swapping of incoming words under b_swap.
module video_fetch_fifo #(
   parameter int WORDS = 2,
   parameter int DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 res,
   input  logic                 fetch_start,
   input  logic                 video_strobe,
   input  logic [15:0]          video_data,
   input  logic                 b_swap,
   input  logic                 fetch_stb,
   output logic [16*WORDS-1:0]  fetch_data,
   output logic                 fetch_valid,
   output logic                 busy,
   output logic [2:0]           word_idx,
   output logic                 ovf
);

   localparam int LW = 16 * WORDS;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [2:0]    LAST_IDX = 3'(WORDS - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic {
      IDLE     = 1'b0,
      ASSEMBLE = 1'b1
   } state_e;

   function automatic logic [15:0] byte_swap(input logic [15:0] w);
      return {w[7:0], w[15:8]};
   endfunction

   state_e            state_q, state_d;
   logic              busy_q, busy_d;
   logic [2:0]        word_idx_q, word_idx_d;
   logic              ovf_q, ovf_d;
   logic [LW-1:0]     fetch_data_q, fetch_data_d;
   logic              fetch_valid_q, fetch_valid_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [15:0]       tmp_q [WORDS];
   logic [15:0]       tmp_d [WORDS];
   logic [LW-1:0]     mem_q [DEPTH];
   logic [LW-1:0]     mem_d [DEPTH];

   logic [15:0]       word_s;
   logic [LW-1:0]     line_s;
   logic              last_s;
   logic              strobe_s;
   logic              push_s;
   logic              full_s;
   logic              empty_s;
   logic              pop_ok_s;
   logic              push_ok_s;

`ifdef VIDEO_FETCH_BSWAP_EN
   assign word_s = b_swap ? byte_swap(video_data) : video_data;
`else
   logic unused_s;
   assign unused_s = b_swap;
   assign word_s   = video_data;
`endif

   assign last_s = (word_idx_q == LAST_IDX);

   // Line assembly control: a start always restarts the line, strobes only count in ASSEMBLE
   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      strobe_s   = 1'b0;
      push_s     = 1'b0;
      case (state_q)
         IDLE: begin
            if (fetch_start) begin
               state_d    = ASSEMBLE;
               word_idx_d = 3'd0;
            end else begin
               state_d    = IDLE;
            end
         end
         ASSEMBLE: begin
            if (fetch_start) begin
               word_idx_d = 3'd0;
            end else if (video_strobe) begin
               strobe_s = 1'b1;
               if (last_s) begin
                  push_s     = 1'b1;
                  word_idx_d = 3'd0;
                  state_d    = IDLE;
               end else begin
                  word_idx_d = word_idx_q + 3'd1;
               end
            end else begin
               word_idx_d = word_idx_q;
            end
         end
         default: begin
            state_d    = IDLE;
            word_idx_d = 3'd0;
         end
      endcase
      busy_d = (state_d == ASSEMBLE);
   end

   // Temp slot writes and the outgoing line; the final word goes straight into the line
   always_comb begin
      for (int k = 0; k < WORDS; k++) begin
         if (strobe_s && (word_idx_q == 3'(k))) begin
            tmp_d[k] = word_s;
         end else begin
            tmp_d[k] = tmp_q[k];
         end
         if (k == WORDS - 1) begin
            line_s[16*k +: 16] = word_s;
         end else begin
            line_s[16*k +: 16] = tmp_q[k];
         end
      end
   end

   // Buffer bookkeeping: pop decisions use the pre-edge occupancy, so no same-cycle bypass
   always_comb begin
      full_s    = (count_q == FULL_CNT);
      empty_s   = (count_q == {CW{1'b0}});
      pop_ok_s  = fetch_stb && !empty_s;
      push_ok_s = push_s && (!full_s || pop_ok_s);
      ovf_d     = ovf_q | (push_s && full_s && !pop_ok_s);

      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d     = rd_ptr_q + PW'(1);
         fetch_data_d = mem_q[rd_ptr_q];
      end else begin
         rd_ptr_d     = rd_ptr_q;
         fetch_data_d = fetch_data_q;
      end
      if (fetch_stb) begin
         fetch_valid_d = pop_ok_s;
      end else begin
         fetch_valid_d = fetch_valid_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      for (int d = 0; d < DEPTH; d++) begin
         if (push_ok_s && (wr_ptr_q == PW'(d))) begin
            mem_d[d] = line_s;
         end else begin
            mem_d[d] = mem_q[d];
         end
      end
   end

   // Control and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (res) begin
         state_q       <= IDLE;
         busy_q        <= 1'b0;
         word_idx_q    <= 3'd0;
         ovf_q         <= 1'b0;
         fetch_data_q  <= {LW{1'b0}};
         fetch_valid_q <= 1'b0;
         wr_ptr_q      <= {PW{1'b0}};
         rd_ptr_q      <= {PW{1'b0}};
         count_q       <= {CW{1'b0}};
      end else begin
         state_q       <= state_d;
         busy_q        <= busy_d;
         word_idx_q    <= word_idx_d;
         ovf_q         <= ovf_d;
         fetch_data_q  <= fetch_data_d;
         fetch_valid_q <= fetch_valid_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
      end
   end

   // Data storage carries no reset; writes are blocked while res is high
   always_ff @(posedge clk) begin
      if (!res) begin
         tmp_q <= tmp_d;
         mem_q <= mem_d;
      end
   end

   assign fetch_data  = fetch_data_q;
   assign fetch_valid = fetch_valid_q;
   assign busy        = busy_q;
   assign word_idx    = word_idx_q;
   assign ovf         = ovf_q;

endmodule

// File: tb/tb_video_fetch_fifo.sv
// Randomized and directed bench for video_fetch_fifo against a queue-based reference model.
module tb_video_fetch_fifo;
   localparam int W  = 2;
   localparam int D  = 2;
   localparam int LW = 16 * W;

   logic            clk = 1'b0;
   logic            res, fetch_start, video_strobe, b_swap, fetch_stb;
   logic [15:0]     video_data;
   logic [LW-1:0]   fetch_data;
   logic            fetch_valid, busy, ovf;
   logic [2:0]      word_idx;

   int n_checks = 0;
   int n_pass   = 0;

   bit              m_asm;
   logic [15:0]     m_part[$];
   logic [LW-1:0]   m_buf[$];
   logic [LW-1:0]   m_fd;
   bit              m_fv, m_ovf;

   video_fetch_fifo #(.WORDS(W), .DEPTH(D)) dut (
      .clk(clk), .res(res), .fetch_start(fetch_start), .video_strobe(video_strobe),
      .video_data(video_data), .b_swap(b_swap), .fetch_stb(fetch_stb),
      .fetch_data(fetch_data), .fetch_valid(fetch_valid), .busy(busy),
      .word_idx(word_idx), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] m_word(input logic [15:0] d, input logic bs);
`ifdef VIDEO_FETCH_BSWAP_EN
      return bs ? {d[7:0], d[15:8]} : d;
`else
      return d;
`endif
   endfunction

   // Reference behaviour: one call per rising edge, using the inputs sampled at that edge
   task automatic model_update();
      int            old_n;
      bit            pop_ok;
      bit            do_push;
      logic [LW-1:0] line;
      old_n   = m_buf.size();
      pop_ok  = fetch_stb && (old_n > 0);
      do_push = 1'b0;
      line    = '0;
      if (res) begin
         m_asm = 1'b0; m_part.delete(); m_buf.delete();
         m_fd = '0; m_fv = 1'b0; m_ovf = 1'b0;
      end else begin
         if (pop_ok) m_fd = m_buf[0];
         if (fetch_stb) m_fv = pop_ok;
         if (!m_asm) begin
            if (fetch_start) begin m_asm = 1'b1; m_part.delete(); end
         end else if (fetch_start) begin
            m_part.delete();
         end else if (video_strobe) begin
            m_part.push_back(m_word(video_data, b_swap));
            if (m_part.size() == W) begin
               for (int k = 0; k < W; k++) line[16*k +: 16] = m_part[k];
               do_push = 1'b1;
               m_part.delete();
               m_asm = 1'b0;
            end
         end
         if (pop_ok) void'(m_buf.pop_front());
         if (do_push) begin
            if (old_n < D || pop_ok) m_buf.push_back(line);
            else m_ovf = 1'b1;
         end
      end
   endtask

   task automatic step(input logic r, input logic st, input logic vs,
                       input logic [15:0] vd, input logic bs, input logic fs);
      res = r; fetch_start = st; video_strobe = vs; video_data = vd; b_swap = bs; fetch_stb = fs;
      @(posedge clk);
      model_update();
      #1;
      chk("busy",        64'(busy),        64'(m_asm));
      chk("word_idx",    64'(word_idx),    64'(m_part.size()));
      chk("ovf",         64'(ovf),         64'(m_ovf));
      chk("fetch_valid", 64'(fetch_valid), 64'(m_fv));
      chk("fetch_data",  64'(fetch_data),  64'(m_fd));
   endtask

   task automatic push_line(input logic [15:0] a, input logic [15:0] b);
      step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, a,        1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, b,        1'b0, 1'b0);
   endtask

   task automatic pop();
      step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1);
   endtask

   initial begin
      res = 1'b1; fetch_start = 1'b0; video_strobe = 1'b0; video_data = 16'h0000;
      b_swap = 1'b0; fetch_stb = 1'b0;

      do_reset();
      chk("rst_busy",  64'(busy),        64'd0);
      chk("rst_idx",   64'(word_idx),    64'd0);
      chk("rst_fv",    64'(fetch_valid), 64'd0);
      chk("rst_fd",    64'(fetch_data),  64'd0);
      chk("rst_ovf",   64'(ovf),         64'd0);

      // Basic line assembly and pop
      push_line(16'h1122, 16'h3344);
      pop();
      chk("basic_data", 64'(fetch_data),  64'h33441122);
      chk("basic_fv",   64'(fetch_valid), 64'd1);

      // Restart discards the partial line
      step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 16'h5555, 1'b0, 1'b0);
      chk("restart_idx", 64'(word_idx), 64'd0);
      step(1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);
      pop();
      chk("restart_data", 64'(fetch_data), 64'h00020001);

      // Overflow on a full buffer, then drain
      push_line(16'h0A01, 16'h0A02);
      push_line(16'h0B01, 16'h0B02);
      push_line(16'h0C01, 16'h0C02);
      chk("ovf_set", 64'(ovf), 64'd1);
      pop();
      chk("ovf_pop1", 64'(fetch_data), 64'h0A020A01);
      pop();
      chk("ovf_pop2", 64'(fetch_data), 64'h0B020B01);
      pop();
      chk("empty_fv",   64'(fetch_valid), 64'd0);
      chk("empty_hold", 64'(fetch_data),  64'h0B020B01);

      // Reset mid-line clears everything, then a fresh line assembles
      step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b1);
      chk("midrst_busy", 64'(busy),        64'd0);
      chk("midrst_idx",  64'(word_idx),    64'd0);
      chk("midrst_ovf",  64'(ovf),         64'd0);
      chk("midrst_fv",   64'(fetch_valid), 64'd0);
      push_line(16'h7001, 16'h7002);
      pop();
      chk("midrst_line", 64'(fetch_data), 64'h70027001);

      // Full buffer with simultaneous push and pop
      do_reset();
      push_line(16'h1001, 16'h1002);
      push_line(16'h2001, 16'h2002);
      step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 16'h3001, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 16'h3002, 1'b0, 1'b1);
      chk("fullpp_ovf",  64'(ovf),        64'd0);
      chk("fullpp_data", 64'(fetch_data), 64'h10021001);
      pop();
      chk("fullpp_pop2", 64'(fetch_data), 64'h20022001);
      pop();
      chk("fullpp_pop3", 64'(fetch_data), 64'h30023001);
      pop();
      chk("fullpp_empty", 64'(fetch_valid), 64'd0);

      // Empty buffer with simultaneous push and pop: no bypass
      step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 16'h4001, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 16'h4002, 1'b0, 1'b1);
      chk("emptypp_fv", 64'(fetch_valid), 64'd0);
      pop();
      chk("emptypp_data", 64'(fetch_data), 64'h40024001);

      // Byte swap configuration
      do_reset();
      step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
      pop();
`ifdef VIDEO_FETCH_BSWAP_EN
      chk("bswap_word", 64'(fetch_data[15:0]), 64'hEFBE);
`else
      chk("bswap_word", 64'(fetch_data[15:0]), 64'hBEEF);
`endif

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 1) == 1),
              16'($urandom),
              ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 3) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/video_fetch_fifo.md
VIDEO_FETCH_FIFO -- requirements
Module: video_fetch_fifo

Interface
REQ-001 The module SHALL have parameter WORDS, default 2, giving the number of 16-bit DRAM words assembled per fetch line (legal 1..8).
REQ-002 The module SHALL have parameter DEPTH, default 2, giving the number of output buffer entries (power of two, 2..8).
REQ-003 The module SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 The module SHALL have port res  input  1  reset, synchronous, active-high.
REQ-005 The module SHALL have port fetch_start  input  1  begin assembly of a new line and clear the word index.
REQ-006 The module SHALL have port video_strobe  input  1  video_data valid this cycle.
REQ-007 The module SHALL have port video_data  input  16  DRAM read word.
REQ-008 The module SHALL have port b_swap  input  1  swap the bytes of video_data before storage (see Configuration).
REQ-009 The module SHALL have port fetch_stb  input  1  pop the buffer head into fetch_data.
REQ-010 The module SHALL have port fetch_data  output  16*WORDS  registered line; word k occupies bits [16k+15:16k].
REQ-011 The module SHALL have port fetch_valid  output  1  fetch_data was loaded by the most recent fetch_stb.
REQ-012 The module SHALL have port busy  output  1  high while in ASSEMBLE.
REQ-013 The module SHALL have port word_idx  output  3  index of the next word to be written.
REQ-014 The module SHALL have port ovf  output  1  sticky flag for a line dropped on a full buffer.

Function
REQ-015 The FSM SHALL have two states, IDLE and ASSEMBLE; busy=1 exactly in ASSEMBLE.
REQ-016 In IDLE, fetch_start SHALL set word_idx=0 and move the FSM to ASSEMBLE; video_strobe in IDLE SHALL be ignored.
REQ-017 In ASSEMBLE, video_strobe without fetch_start SHALL write the (optionally swapped) word into temp slot word_idx and increment word_idx.
REQ-018 On the strobe with word_idx=WORDS-1, the complete line, including the current word, SHALL be pushed into the buffer on that same edge, word_idx SHALL return to 0, and the FSM SHALL return to IDLE.
REQ-019 fetch_start in ASSEMBLE SHALL discard the partial line, set word_idx=0 and remain in ASSEMBLE; a coincident video_strobe SHALL be ignored.
REQ-020 A push to a full buffer without a coincident pop SHALL drop the line, leave the buffer unchanged, and set ovf=1 until res.
REQ-021 fetch_stb with the buffer non-empty SHALL load the head into fetch_data, pop it, and set fetch_valid=1 on the next edge.
REQ-022 fetch_stb with the buffer empty SHALL hold fetch_data and set fetch_valid=0.
REQ-023 fetch_valid SHALL change only on fetch_stb or res.
REQ-024 Buffer bypass is not provided: a line pushed on edge N SHALL be poppable no earlier than a fetch_stb sampled at edge N+1.
REQ-025 A push and pop in the same cycle on a full buffer SHALL both succeed without setting ovf.
REQ-026 A push and pop in the same cycle on an empty buffer SHALL store the line and return fetch_valid=0.
REQ-027 Buffer pointers SHALL wrap modulo DEPTH; occupancy SHALL use a clog2(DEPTH)+1-bit counter.

Reset
REQ-028 res SHALL override all other inputs in the same cycle.
REQ-029 While res=1, the FSM SHALL go to IDLE and word_idx, the buffer pointers, occupancy, fetch_data, fetch_valid and ovf SHALL be set to 0.
REQ-030 Reset during ASSEMBLE SHALL discard the partial line.
REQ-031 Temp-slot and buffer storage contents SHALL NOT require reset.

Configuration
REQ-032 With macro VIDEO_FETCH_BSWAP_EN defined, b_swap=1 SHALL store {video_data[7:0],video_data[15:8]}.
REQ-033 Without VIDEO_FETCH_BSWAP_EN, the b_swap port SHALL be present but ignored, and data SHALL be stored unswapped.

Verification
REQ-034 WORDS=2: start, then strobes 0x1122 and 0x3344, then fetch_stb -> fetch_data=0x33441122, fetch_valid=1.
REQ-035 Start, one strobe 0xAAAA, start again, then strobes 0x0001 and 0x0002, then pop -> 0x00020001, with no trace of 0xAAAA.
REQ-036 DEPTH=2: push three lines without a pop -> ovf=1; two pops return lines 1 and 2; a third pop gives fetch_valid=0 and fetch_data unchanged.
REQ-037 Full buffer with push and pop in the same cycle -> ovf stays 0, occupancy stays 2, and FIFO order is preserved.
REQ-038 With VIDEO_FETCH_BSWAP_EN defined, b_swap=1 and strobe 0xBEEF -> stored word 0xEFBE; with the macro undefined -> 0xBEEF.
REQ-039 res asserted after one of two strobes -> busy=0, word_idx=0, ovf=0, fetch_valid=0; the next full line assembles correctly.
